// File: rtl/ccff_loader.sv
// Serial loader for a configuration flip-flop chain: unpacks bitstream words
// LSB-first onto the chain head and gates the chain shift clock per bit.
module ccff_loader #(
    parameter int unsigned CHAIN_LEN = 64,
    parameter int unsigned WORD_W    = 8,
    parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              pReset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] bs_data,
    input  logic              bs_valid,
    output logic              bs_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    output logic              config_enable,
    output logic [CNT_W-1:0]  bit_count,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int unsigned BL_W = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        FINISH = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [WORD_W-1:0]   shreg_q, shreg_d;
    logic [BL_W-1:0]     bits_left_q, bits_left_d;
    logic [CNT_W-1:0]    bit_count_q, bit_count_d;
    logic                error_q, error_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic                cfg_en_q, cfg_en_d;
    logic                ready_q, ready_d;
    logic                shift_en_q, shift_en_d;
    logic                head_q, head_d;
    logic                handshake;
    logic                last_bit;

    // Next-state and next-output logic; registered outputs mirror the next state.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bits_left_d = bits_left_q;
        bit_count_d = bit_count_q;
        error_d     = error_q;
        done_d      = 1'b0;
        handshake   = bs_valid && ready_q;
        last_bit    = shift_en_q && (bit_count_q == CNT_W'(CHAIN_LEN - 1));

        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d     = LOAD;
                    bit_count_d = '0;
                    error_d     = 1'b0;
                    bits_left_d = '0;
                    shreg_d     = '0;
                end
            end
            LOAD: begin
                if (shift_en_q) begin
                    shreg_d     = shreg_q >> 1;
                    bits_left_d = bits_left_q - BL_W'(1);
                    if (bit_count_q != CNT_W'(CHAIN_LEN)) begin
                        bit_count_d = bit_count_q + CNT_W'(1);
                    end
                end
                // A new word may land on the same edge the previous word's last bit leaves.
                if (handshake) begin
                    shreg_d     = bs_data;
                    bits_left_d = BL_W'(WORD_W);
                end
                if (abort) begin
                    state_d     = IDLE;
                    error_d     = 1'b1;
                    bits_left_d = '0;
                end else if (last_bit) begin
                    state_d     = FINISH;
                    bits_left_d = '0;
                    shreg_d     = '0;
                    done_d      = 1'b1;
                end
            end
            FINISH: begin
                state_d = IDLE;
                if (abort) begin
                    error_d = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                bits_left_d = '0;
            end
        endcase

        busy_d     = (state_d != IDLE);
        cfg_en_d   = (state_d != IDLE);
        ready_d    = (state_d == LOAD) && (bits_left_d <= BL_W'(1));
        shift_en_d = (state_d == LOAD) && (bits_left_d != '0);
        head_d     = shift_en_d ? shreg_d[0] : head_q;
    end

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            bits_left_q <= '0;
            bit_count_q <= '0;
            error_q     <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            cfg_en_q    <= 1'b0;
            ready_q     <= 1'b0;
            shift_en_q  <= 1'b0;
            head_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bits_left_q <= bits_left_d;
            bit_count_q <= bit_count_d;
            error_q     <= error_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            cfg_en_q    <= cfg_en_d;
            ready_q     <= ready_d;
            shift_en_q  <= shift_en_d;
            head_q      <= head_d;
        end
    end

    assign bs_ready      = ready_q;
    assign ccff_head     = head_q;
    assign ccff_shift_en = shift_en_q;
    assign config_enable = cfg_en_q;
    assign bit_count     = bit_count_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;

endmodule

// File: tb/tb_ccff_loader.sv
// Bench for ccff_loader: directed scenarios plus random loads checked every
// cycle against a bit-queue model of the load.
module tb_ccff_loader;

    localparam int unsigned CL = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0;
    logic       start = 1'b0, abort = 1'b0, bs_valid = 1'b0;
    logic [7:0] bs_data = '0;
    logic       bs_ready, ccff_head, ccff_shift_en, config_enable, busy, done, error;
    logic [4:0] bit_count;

    logic       start12 = 1'b0, abort12 = 1'b0, bs_valid12 = 1'b0;
    logic [7:0] bs_data12 = '0;
    logic       bs_ready12, head12, shift_en12, cfg12, busy12, done12, error12;
    logic [3:0] bit_count12;

    ccff_loader #(.CHAIN_LEN(16), .WORD_W(8)) u16 (
        .prog_clk(clk), .pReset_n(rst_n), .start(start), .abort(abort),
        .bs_data(bs_data), .bs_valid(bs_valid), .bs_ready(bs_ready),
        .ccff_head(ccff_head), .ccff_shift_en(ccff_shift_en),
        .config_enable(config_enable), .bit_count(bit_count), .busy(busy),
        .done(done), .error(error)
    );

    ccff_loader #(.CHAIN_LEN(12), .WORD_W(8)) u12 (
        .prog_clk(clk), .pReset_n(rst_n), .start(start12), .abort(abort12),
        .bs_data(bs_data12), .bs_valid(bs_valid12), .bs_ready(bs_ready12),
        .ccff_head(head12), .ccff_shift_en(shift_en12),
        .config_enable(cfg12), .bit_count(bit_count12), .busy(busy12),
        .done(done12), .error(error12)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: phase 0 idle, 1 loading, 2 finishing; bq holds unshifted bits.
    int         m_phase = 0;
    int         m_avail = 0;
    int         m_shifted = 0;
    bit         m_err = 1'b0;
    bit         last_head = 1'b0;
    bit         bq[$];
    logic [7:0] stream[$];
    int         cyc = 0, start_cyc = 0, lat = -1, hs_cnt = 0;
    logic [15:0] hv;
    int         hn = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        bit e_shift;
        bit e_head;
        e_shift = (m_phase == 1) && (m_avail > 0);
        e_head  = (e_shift && bq.size() > 0) ? bq[0] : last_head;
        chk("shift_en", 32'(ccff_shift_en), 32'(e_shift));
        chk("bs_ready", 32'(bs_ready), 32'((m_phase == 1) && (m_avail <= 1)));
        chk("busy", 32'(busy), 32'(m_phase != 0));
        chk("config_enable", 32'(config_enable), 32'(m_phase != 0));
        chk("done", 32'(done), 32'(m_phase == 2));
        chk("error", 32'(error), 32'(m_err));
        chk("bit_count", 32'(bit_count), 32'(m_shifted));
        chk("ccff_head", 32'(ccff_head), 32'(e_head));
        if (ccff_shift_en === 1'b1 && hn < 16) begin
            hv[hn] = ccff_head;
            hn++;
        end
        if (done === 1'b1) lat = cyc - start_cyc;
    endtask

    // One clock: check outputs, apply inputs, advance the model, wait a cycle.
    task automatic step(input bit st, input bit ab, input bit vld);
        bit hs;
        bit sh;
        check_outputs();
        start    = st;
        abort    = ab;
        bs_valid = vld;
        bs_data  = (stream.size() > 0) ? stream[0] : 8'($urandom);
        hs = vld && (m_phase == 1) && (m_avail <= 1);
        if (st && !ab && m_phase == 0) start_cyc = cyc;
        case (m_phase)
            0: if (st && !ab) begin
                m_phase = 1; m_shifted = 0; m_err = 1'b0; m_avail = 0; bq.delete();
            end
            1: begin
                sh = (m_avail > 0);
                if (sh) begin
                    m_avail--; m_shifted++; last_head = bq.pop_front();
                end
                if (hs) begin
                    bq.delete();
                    for (int i = 0; i < 8; i++) bq.push_back(bs_data[i]);
                    m_avail = 8;
                    hs_cnt++;
                end
                if (ab) begin
                    m_phase = 0; m_err = 1'b1; m_avail = 0;
                end else if (sh && m_shifted == CL) begin
                    m_phase = 2; m_avail = 0; bq.delete();
                end
            end
            default: begin
                m_phase = 0;
                if (ab) m_err = 1'b1;
            end
        endcase
        if (hs && stream.size() > 0) void'(stream.pop_front());
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    int drop, dropped, n12, shifts12, done12_seen, ready_after;
    logic [11:0] h12;

    initial begin
        repeat (2) @(negedge clk);
        check_outputs();
        rst_n = 1'b1;
        repeat (3) step(0, 0, 1);

        // Two-word stream into a 16-bit chain, valid always high.
        stream = '{8'hA5, 8'h3C, 8'h5A};
        hn = 0; lat = -1;
        step(1, 0, 1);
        repeat (20) step(0, 0, 1);
        chk("seq_head", 32'(hv), 32'h3CA5);
        chk("seq_shifts", 32'(hn), 32'd16);
        chk("seq_latency", 32'(lat), 32'd18);

        // Valid dropped three cycles at the word boundary.
        stream = '{8'hA5, 8'h3C, 8'h77};
        hn = 0; hs_cnt = 0; drop = 0; dropped = 0;
        step(1, 0, 1);
        for (int c = 0; c < 40 && m_phase != 0; c++) begin
            if (!dropped && hs_cnt == 1 && m_phase == 1 && m_avail <= 1) begin
                drop = 3; dropped = 1;
            end
            if (drop > 0) begin
                drop--;
                step(0, 0, 0);
            end else begin
                step(0, 0, 1);
            end
        end
        chk("stall_done", 32'(m_phase), 32'd0);
        chk("stall_head", 32'(hv), 32'h3CA5);

        // Abort on the fifth bit, then restart clears the error.
        stream = '{8'h96, 8'h69};
        step(1, 0, 1);
        for (int c = 0; c < 20 && !(m_phase == 1 && m_avail > 0 && m_shifted == 4); c++)
            step(0, 0, 1);
        step(0, 1, 1);
        chk("abort_count", 32'(bit_count), 32'd5);
        chk("abort_error", 32'(error), 32'd1);
        chk("abort_cfg", 32'(config_enable), 32'd0);
        repeat (3) step(0, 0, 0);
        stream = '{8'h12, 8'h34};
        step(1, 0, 1);
        step(0, 0, 1);
        chk("restart_error", 32'(error), 32'd0);
        for (int c = 0; c < 30 && m_phase != 0; c++) step(0, 0, 1);

        // Start during LOAD ignored; abort lands on the final-bit edge.
        stream = '{8'hC3, 8'h81};
        step(1, 0, 1);
        for (int c = 0; c < 30 && !(m_phase == 1 && m_avail > 0 && m_shifted == 15); c++)
            step(c == 5, 0, 1);
        step(0, 1, 1);
        chk("finabort_error", 32'(error), 32'd1);
        chk("finabort_done", 32'(done), 32'd0);
        chk("finabort_count", 32'(bit_count), 32'd16);
        repeat (2) step(0, 0, 0);

        // Reset pulse mid-load, then a full load.
        stream = '{8'hF0, 8'h0F};
        step(1, 0, 1);
        repeat (6) step(0, 0, 1);
        #2 rst_n = 1'b0;
        start = 1'b0; abort = 1'b0; bs_valid = 1'b0;
        #1;
        chk("rst_outs", 32'({bs_ready, ccff_head, ccff_shift_en, config_enable, busy,
                             done, error, bit_count}), 32'd0);
        m_phase = 0; m_avail = 0; m_shifted = 0; m_err = 1'b0; last_head = 1'b0; bq.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        stream = '{8'hA5, 8'h3C, 8'h00};
        hn = 0;
        step(1, 0, 1);
        for (int c = 0; c < 30 && m_phase != 0; c++) step(0, 0, 1);
        chk("post_rst_head", 32'(hv), 32'h3CA5);

        // Random loads with gaps, stray starts and occasional aborts.
        for (int l = 0; l < 8; l++) begin
            stream.delete();
            repeat (4) stream.push_back(8'($urandom));
            step(1, 0, 1);
            for (int c = 0; c < 60 && m_phase != 0; c++)
                step(($urandom % 12) == 0, ($urandom % 45) == 0, ($urandom % 4) != 0);
            repeat (2) step(0, 0, 0);
        end

        // Twelve-bit chain: only the low nibble of the second word shifts.
        chk("u12_idle_ready", 32'(bs_ready12), 32'd0);
        n12 = 0; shifts12 = 0; done12_seen = 0; ready_after = 0; h12 = '0;
        start12 = 1'b1;
        step(0, 0, 0);
        start12 = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (shift_en12 === 1'b1) begin
                if (shifts12 < 12) h12[shifts12] = head12;
                shifts12++;
            end
            if (done12_seen > 0 && bs_ready12 === 1'b1) ready_after++;
            if (done12 === 1'b1) done12_seen++;
            bs_valid12 = 1'b1;
            bs_data12  = (n12 == 0) ? 8'hFF : 8'h0F;
            if (bs_ready12 === 1'b1) n12++;
            step(0, 0, 0);
        end
        bs_valid12 = 1'b0;
        chk("u12_shifts", 32'(shifts12), 32'd12);
        chk("u12_head", 32'(h12), 32'hFFF);
        chk("u12_bit_count", 32'(bit_count12), 32'd12);
        chk("u12_done", 32'(done12_seen), 32'd1);
        chk("u12_words", 32'(n12), 32'd2);
        chk("u12_ready_after", 32'(ready_after), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ccff_loader.md
CCFF_LOADER -- requirements
Module: ccff_loader

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 64: number of configuration flip-flops in the downstream CCFF chain.
REQ-002 SHALL have parameter WORD_W, default 8: bitstream word width.
REQ-003 SHALL have parameter CNT_W, default $clog2(CHAIN_LEN+1): width of the bit counter.
REQ-004 SHALL have port prog_clk  input  1  programming clock; all state changes on its rising edge.
REQ-005 SHALL have port pReset_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a chain load.
REQ-007 SHALL have port abort  input  1  terminate the current load.
REQ-008 SHALL have port bs_data  input  WORD_W  bitstream word, LSB shifted first.
REQ-009 SHALL have port bs_valid  input  1  bs_data valid.
REQ-010 SHALL have port bs_ready  output  1  loader accepts bs_data this cycle.
REQ-011 SHALL have port ccff_head  output  1  serial data into the chain head.
REQ-012 SHALL have port ccff_shift_en  output  1  chain advances one bit on this edge (drives the prog_clk gate).
REQ-013 SHALL have port config_enable  output  1  chain in configuration mode.
REQ-014 SHALL have port bit_count  output  CNT_W  bits shifted into the chain in the current load.
REQ-015 SHALL have port busy  output  1  load in progress.
REQ-016 SHALL have port done  output  1  one-cycle pulse: load complete.
REQ-017 SHALL have port error  output  1  sticky flag: last load was aborted.

Function
REQ-018 SHALL implement states IDLE, LOAD, FINISH.
REQ-019 IDLE: start=1 SHALL clear bit_count and error, enter LOAD and set config_enable=1 and busy=1 on the next cycle.
REQ-020 start in LOAD or FINISH SHALL be ignored.
REQ-021 Internal shift register plus bits_left counter (0..WORD_W). bs_ready SHALL be 1 in LOAD when bits_left<=1, and 0 in all other states.
REQ-022 A handshake (bs_valid & bs_ready) SHALL load shreg=bs_data and bits_left=WORD_W. This includes the cycle in which the final bit of the previous word shifts, so back-to-back words shift with no bubble.
REQ-023 In LOAD with bits_left>0, ccff_shift_en SHALL be 1, ccff_head SHALL equal shreg[0], and at the edge shreg SHALL shift right, bits_left SHALL decrement and bit_count SHALL increment.
REQ-024 With bits_left=0 (starved), ccff_shift_en SHALL be 0 and ccff_head SHALL hold its last value; the chain does not advance.
REQ-025 ccff_shift_en SHALL never be 1 outside LOAD.
REQ-026 When bit_count reaches CHAIN_LEN: enter FINISH, deassert ccff_shift_en, discard remaining shreg bits, force bs_ready=0.
REQ-027 FINISH SHALL last exactly one cycle, with done=1 and config_enable=1; then return to IDLE with config_enable=0 and busy=0.
REQ-028 abort=1 in LOAD or FINISH SHALL set error=1, return to IDLE at the next edge, suppress done, and clear bits_left. bit_count SHALL hold its value for inspection.
REQ-029 abort coincident with the final-bit edge: abort wins, error=1, done=0; the final bit still shifts.
REQ-030 abort in IDLE SHALL have no effect. start and abort in the same IDLE cycle: start is ignored.
REQ-031 bit_count SHALL saturate at CHAIN_LEN and never wrap.
REQ-032 Total latency from start to done with bs_valid held 1: CHAIN_LEN+2 cycles.

Reset
REQ-033 pReset_n=0 SHALL asynchronously force state=IDLE and set bs_ready, ccff_head, ccff_shift_en, config_enable, busy, done, error, bit_count, bits_left and shreg to 0. This holds mid-load: the partial load is lost.
REQ-034 Release of pReset_n SHALL be synchronous to prog_clk. The first edge after release starts from IDLE.

Verification
REQ-035 CHAIN_LEN=16, WORD_W=8, words 0xA5, 0x3C streamed, bs_valid always 1 -> ccff_head sequence 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0; 16 consecutive ccff_shift_en cycles; done at cycle 18 after start; bs_ready=0 in IDLE.
REQ-036 CHAIN_LEN=12, one 0xFF and one 0x0F word -> only 4 bits of the second word shift; done asserted; bit_count=12; no further bs_ready.
REQ-037 bs_valid dropped for 3 cycles mid-word boundary -> ccff_shift_en=0 for those cycles, ccff_head held, bit_count frozen, final chain contents identical to REQ-035.
REQ-038 abort after 5 bits -> error=1, bit_count=5, done never pulses, config_enable=0 next cycle; subsequent start clears error.
REQ-039 pReset_n low for 1 cycle mid-load -> all outputs 0 immediately, state IDLE; start after release completes a full 16-bit load.
REQ-040 start pulsed during LOAD, and abort on the final-bit edge -> the start is ignored; error=1, done=0.
